// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FSM sequencing fetch/decode/exec/mem/writeback for an RV32I multi-cycle core
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_o,
    input  logic             imem_ready_i,
    output logic             ir_write_o,
    input  logic [6:0]       opcode_i,
    input  logic             dec_regwrite_i,
    input  logic             dec_memread_i,
    input  logic             dec_memwrite_i,
    input  logic             dec_branch_i,
    input  logic             dec_jump_i,
    input  logic             branch_taken_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    input  logic             dmem_ready_i,
    output logic             rf_we_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_sel_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             trap_o,
    output logic             illegal_instr_o,
    output logic             bus_error_o,
    output logic [2:0]       state_dbg_o
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam int WW = $clog2(MEM_TIMEOUT + 2);

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             bus_q, bus_d;
    logic             legal;
    logic             timeout;

    assign legal = opcode_i inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                    7'b1100011, 7'b0010111, 7'b0110111, 7'b1101111};
    assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WW'(MEM_TIMEOUT));

    // Next state, handshake/strobe decode and sticky cause updates
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        bus_d      = bus_q;
        imem_req_o = 1'b0;
        ir_write_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        rf_we_o    = 1'b0;
        pc_write_o = 1'b0;
        pc_sel_o   = 2'b00;
        retire_o   = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    ir_write_o = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout) begin
                    bus_d   = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                state_d   = legal ? S_EXEC : S_TRAP;
                illegal_d = illegal_q | ~legal;
            end
            S_EXEC: begin
                if (dec_memread_i || dec_memwrite_i) begin
                    state_d = S_MEM;
                end else if (dec_branch_i) begin
                    pc_write_o = 1'b1;
                    pc_sel_o   = {1'b0, branch_taken_i};
                    retire_o   = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = dec_memwrite_i;
                if (dmem_ready_i) begin
                    pc_write_o = dec_memwrite_i;
                    retire_o   = dec_memwrite_i;
                    state_d    = dec_memwrite_i ? S_FETCH : S_WB;
                end else if (timeout) begin
                    bus_d   = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                rf_we_o    = dec_regwrite_i;
                pc_write_o = 1'b1;
                pc_sel_o   = dec_jump_i ? 2'b10 : 2'b00;
                retire_o   = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_RESET;
        endcase
        wait_d    = (state_d != state_q) ? '0 : (imem_req_o || dmem_req_o) ? wait_q + WW'(1) : wait_q;
        instret_d = retire_o ? instret_q + CNT_W'(1) : instret_q;
    end

    // State, wait counter, retire counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_q     <= bus_d;
        end
    end

    assign instret_o       = instret_q;
    assign trap_o          = (state_q == S_TRAP);
    assign illegal_instr_o = illegal_q;
    assign bus_error_o     = bus_q;
    assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction stream checked against a per-instruction timeline model
module tb_multicycle_sequencer;
    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [11:0] REQ = 12'h800, IRW = 12'h400, DREQ = 12'h200, DWE = 12'h100;
    localparam logic [11:0] RFW = 12'h080, PCW = 12'h040, SEL_J = 12'h020, SEL_BR = 12'h010;
    localparam logic [11:0] RET = 12'h008, TRP = 12'h004, ILL = 12'h002, BUS = 12'h001;
    localparam logic [2:0] ST_RST = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3;
    localparam logic [2:0] ST_M = 3'd4, ST_W = 3'd5, ST_T = 3'd6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req, imem_ready = 1'b0, ir_write;
    logic [6:0]    opcode = '0;
    logic          dec_regwrite = 1'b0, dec_memread = 1'b0, dec_memwrite = 1'b0;
    logic          dec_branch = 1'b0, dec_jump = 1'b0, branch_taken = 1'b0;
    logic          dmem_req, dmem_we, dmem_ready = 1'b0;
    logic          rf_we, pc_write, retire, trap, illegal_instr, bus_error;
    logic [1:0]    pc_sel;
    logic [CW-1:0] instret;
    logic [2:0]    state_dbg;
    logic [11:0]   obs;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [6:0]    alu_ops [4] = '{7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111};

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req), .imem_ready_i(imem_ready), .ir_write_o(ir_write),
        .opcode_i(opcode), .dec_regwrite_i(dec_regwrite), .dec_memread_i(dec_memread),
        .dec_memwrite_i(dec_memwrite), .dec_branch_i(dec_branch), .dec_jump_i(dec_jump),
        .branch_taken_i(branch_taken), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .dmem_ready_i(dmem_ready), .rf_we_o(rf_we), .pc_write_o(pc_write), .pc_sel_o(pc_sel),
        .retire_o(retire), .instret_o(instret), .trap_o(trap), .illegal_instr_o(illegal_instr),
        .bus_error_o(bus_error), .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, pc_sel,
                  retire, trap, illegal_instr, bus_error};

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b0010111, 7'b0110111, 7'b1101111};
    endfunction

    task automatic check(input string tag, input logic [2:0] st, input logic [11:0] ex);
        checks += 3;
        assert (state_dbg === st) else begin
            errors++;
            $error("FAIL %s state_dbg got %0d expected %0d", tag, state_dbg, st);
        end
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s outputs got %h expected %h", tag, obs, ex);
        end
        assert (instret === exp_cnt) else begin
            errors++;
            $error("FAIL %s instret got %0d expected %0d", tag, instret, exp_cnt);
        end
    endtask

    task automatic tick(input string tag, input logic [2:0] st, input logic [11:0] ex);
        #4;
        check(tag, st, ex);
        @(posedge clk);
        #1;
        if (ex[3]) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic noise();
        imem_ready   = 1'($urandom_range(0, 1));
        dmem_ready   = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        noise();
        exp_cnt = '0;
        #1;
        check("rst_async", ST_RST, 12'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        noise();
        tick("rst_release", ST_RST, 12'h000);
    endtask

    task automatic trap_hold(input logic [11:0] cause, input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            opcode = 7'($urandom);
            tick("trap", ST_T, TRP | cause);
        end
    endtask

    // cls: 0 ALU, 1 JAL, 2 load, 3 store, 4 branch, 5 ECALL (illegal), 6 random illegal
    task automatic run_instr(input int cls, input int iw, input int dw, input bit tk, input int rst_k);
        logic [6:0] op;
        case (cls)
            0: op = alu_ops[$urandom_range(0, 3)];
            1: op = 7'b1101111;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b1110011;
            default: begin
                do op = 7'($urandom); while (is_legal(op));
            end
        endcase
        opcode       = op;
        dec_regwrite = (cls <= 2);
        dec_memread  = (cls == 2);
        dec_memwrite = (cls == 3);
        dec_branch   = (cls == 4);
        dec_jump     = (cls == 1);
        for (int k = 0; ; k++) begin
            if (k == TO + 1) begin
                trap_hold(BUS, 3);
                return;
            end
            noise();
            imem_ready = (k == iw);
            tick("fetch", ST_F, REQ | ((k == iw) ? IRW : 12'h000));
            if (k == iw) break;
        end
        noise();
        tick("decode", ST_D, 12'h000);
        if (cls >= 5) begin
            trap_hold(ILL, 20);
            return;
        end
        noise();
        branch_taken = tk;
        if (cls == 4) begin
            tick("exec_branch", ST_E, PCW | RET | (tk ? SEL_BR : 12'h000));
            return;
        end
        tick("exec", ST_E, 12'h000);
        if (cls == 2 || cls == 3) begin
            for (int k = 0; ; k++) begin
                if (k == TO + 1) begin
                    trap_hold(BUS, 3);
                    return;
                end
                noise();
                dmem_ready = (k == dw);
                if (k == rst_k) begin
                    do_reset();
                    return;
                end
                tick("mem", ST_M, DREQ | ((cls == 3) ? DWE : 12'h000) |
                     ((k == dw && cls == 3) ? (PCW | RET) : 12'h000));
                if (k == dw) break;
            end
            if (cls == 3) return;
        end
        noise();
        tick("wb", ST_W, RFW | PCW | RET | ((cls == 1) ? SEL_J : 12'h000));
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        run_instr(0, 0, 0, 1'b0, -1);
        run_instr(2, 0, 3, 1'b0, -1);
        run_instr(4, 0, 0, 1'b1, -1);
        run_instr(4, 0, 0, 1'b0, -1);
        run_instr(1, 0, 0, 1'b0, -1);
        run_instr(3, 0, 0, 1'b0, -1);
        run_instr(0, TO, 0, 1'b0, -1);
        run_instr(2, 1, TO, 1'b0, -1);
        run_instr(3, 2, TO, 1'b0, -1);
        for (int i = 0; i < 40; i++)
            run_instr($urandom_range(0, 4), $urandom_range(0, TO), $urandom_range(0, TO),
                      1'($urandom_range(0, 1)), -1);
        run_instr(5, 0, 0, 1'b0, -1);
        do_reset();
        run_instr(6, 1, 0, 1'b0, -1);
        do_reset();
        run_instr(0, TO + 1, 0, 1'b0, -1);
        do_reset();
        run_instr(3, 0, TO + 1, 1'b0, -1);
        do_reset();
        run_instr(0, 0, 0, 1'b0, -1);
        run_instr(2, 0, 3, 1'b0, 2);
        run_instr(0, 0, 0, 1'b0, -1);
        run_instr(4, 1, 0, 1'b1, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
